btn_press_sync: RTL and testbench

Front-end input stage for the signed 8-bit add/subtract datapath. It synchronises and debounces the four raw push-buttons and generates the slow `clk_prs` strobe clock. It delivers each clean press to the control FSM as a `btn_de` flag that is guaranteed to be sampled on exactly one rising edge of `clk_prs`. It runs entirely on the board clock and feeds the control FSM directly.

---
 rtl/btn_press_sync.sv | 89 ++++++++
 tb/tb_btn_press_sync.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_sync.sv
// rtl/btn_press_sync.sv - button synchroniser/debouncer with clk_prs strobe and one-phase press flags
module btn_press_sync #(
    parameter int DEB_CNT = 1000000,
    parameter int PRS_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic       clk_prs,
    output logic [3:0] btn_de
);

    localparam int CW = $clog2(DEB_CNT);
    localparam int PW = $clog2(PRS_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CNT - 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRS_DIV - 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    deb;
    logic [3:0]    seen;
    logic [CW-1:0] cnt [4];
    logic [PW-1:0] pcnt;

    logic       wrap;
    logic       rise;
    logic       fall;
    logic [3:0] press;

    always_comb begin
        wrap = (pcnt == PCNT_MAX);
        rise = wrap & ~clk_prs;
        fall = wrap & clk_prs;
        for (int i = 0; i < 4; i++) begin
            press[i] = s2[i] & ~deb[i] & (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            seen    <= '0;
            btn_de  <= '0;
            pcnt    <= '0;
            clk_prs <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= btn_raw;
            s2 <= s1;

            pcnt <= wrap ? '0 : pcnt + 1'b1;
            if (wrap) begin
                clk_prs <= ~clk_prs;
            end

            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end

                // seen marks a flag the downstream FSM sampled on this high phase's rise
                if (rise) begin
                    seen[i] <= btn_de[i];
                end
                if (fall && seen[i]) begin
                    btn_de[i] <= 1'b0;
                    seen[i]   <= 1'b0;
                end
                // a new press beats the clear; on a fall edge it must wait a full phase
                if (press[i]) begin
                    btn_de[i] <= 1'b1;
                    if (fall) begin
                        seen[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_press_sync.sv
// tb/tb_btn_press_sync.sv - directed bench for btn_press_sync with DEB_CNT=4, PRS_DIV=3
module tb_btn_press_sync;

    localparam int DEB = 4;
    localparam int PRS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = 4'h0;
    logic       clk_prs;
    logic [3:0] btn_de;

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;

    always #5 clk = ~clk;

    btn_press_sync #(
        .DEB_CNT(DEB),
        .PRS_DIV(PRS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .clk_prs(clk_prs),
        .btn_de (btn_de)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset(input logic [3:0] raw, input int cyc);
        reset = 1'b0;
        btn_raw = raw;
        repeat (cyc) tick();
        reset = 1'b1;
        n = 0;
    endtask

    // n counts edges since reset release; clk_prs is high after edges 3..5, 9..11, ...
    function automatic logic exp_prs(input int e);
        return ((e / PRS) % 2) == 1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        btn_raw = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (clk_prs !== 1'b0 || btn_de !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got prs=%b de=%b want prs=0 de=0000", i, clk_prs, btn_de);
            end
        end
        btn_raw = 4'h0;
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (clk_prs !== exp_prs(n) || btn_de !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_release n=%0d got prs=%b de=%b want prs=%b de=0000", n, clk_prs, btn_de, exp_prs(n));
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp;
        logic [3:0] prev_de;
        logic       prev_prs;
        int         hits;
        do_reset(4'h0, 2);
        prev_de = 4'h0;
        prev_prs = 1'b0;
        hits = 0;
        for (int i = 0; i < 45; i++) begin
            btn_raw[1] = (n + 1 >= 2) && (n + 1 <= 31);
            tick();
            exp = (n >= 7 && n <= 11) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp || clk_prs !== exp_prs(n)) begin
                n_bad++;
                $display("FAIL clean_press n=%0d got de=%b prs=%b want de=%b prs=%b", n, btn_de, clk_prs, exp, exp_prs(n));
            end
            if (clk_prs && !prev_prs && prev_de[1]) hits++;
            prev_de = btn_de;
            prev_prs = clk_prs;
        end
        n_cmp++;
        if (hits !== 1) begin
            n_bad++;
            $display("FAIL clean_press_hits got %0d want 1", hits);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp;
        logic [3:0] prev_de;
        logic       prev_prs;
        int         hits;
        do_reset(4'h0, 2);
        prev_de = 4'h0;
        prev_prs = 1'b0;
        hits = 0;
        for (int i = 0; i < 45; i++) begin
            btn_raw[2] = (n + 1 <= 24) ? ((n + 1) % 4 != 0) : 1'b1;
            tick();
            exp = (n >= 30 && n <= 35) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp) begin
                n_bad++;
                $display("FAIL bounce n=%0d got de=%b want de=%b", n, btn_de, exp);
            end
            if (clk_prs && !prev_prs && prev_de[2]) hits++;
            prev_de = btn_de;
            prev_prs = clk_prs;
        end
        n_cmp++;
        if (hits !== 1) begin
            n_bad++;
            $display("FAIL bounce_hits got %0d want 1", hits);
        end
    endtask

    task automatic test_merged();
        logic [3:0] exp;
        logic [3:0] prev_de;
        logic       prev_prs;
        int         hits;
        do_reset(4'h0, 2);
        prev_de = 4'h0;
        prev_prs = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw[0] = (n + 1 >= 4);
            btn_raw[3] = ((n + 1 >= 4) && (n + 1 <= 7)) || (n + 1 >= 12);
            tick();
            exp = (n >= 9 && n <= 17) ? 4'b1001 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp) begin
                n_bad++;
                $display("FAIL merged n=%0d got de=%b want de=%b", n, btn_de, exp);
            end
            if (clk_prs && !prev_prs && prev_de[3]) hits++;
            prev_de = btn_de;
            prev_prs = clk_prs;
        end
        n_cmp++;
        if (hits !== 1) begin
            n_bad++;
            $display("FAIL merged_hits got %0d want 1", hits);
        end
    endtask

    task automatic test_set_wins();
        logic [3:0] exp;
        logic [3:0] prev_de;
        logic       prev_prs;
        int         hits;
        do_reset(4'h0, 2);
        prev_de = 4'h0;
        prev_prs = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw[1] = ((n + 1 >= 5) && (n + 1 <= 8)) || (n + 1 >= 13);
            tick();
            exp = (n >= 10 && n <= 23) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp) begin
                n_bad++;
                $display("FAIL set_wins n=%0d got de=%b want de=%b", n, btn_de, exp);
            end
            if (clk_prs && !prev_prs && prev_de[1]) hits++;
            prev_de = btn_de;
            prev_prs = clk_prs;
        end
        n_cmp++;
        if (hits !== 2) begin
            n_bad++;
            $display("FAIL set_wins_hits got %0d want 2", hits);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        do_reset(4'h0, 2);
        btn_raw = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (n >= 6) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp || clk_prs !== exp_prs(n)) begin
                n_bad++;
                $display("FAIL reset_mid_pre n=%0d got de=%b prs=%b want de=%b prs=%b", n, btn_de, clk_prs, exp, exp_prs(n));
            end
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (btn_de !== 4'h0 || clk_prs !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_clear got de=%b prs=%b want de=0000 prs=0", btn_de, clk_prs);
        end
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            exp = (n >= 6 && n <= 11) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (btn_de !== exp || clk_prs !== exp_prs(n)) begin
                n_bad++;
                $display("FAIL reset_mid_post n=%0d got de=%b prs=%b want de=%b prs=%b", n, btn_de, clk_prs, exp, exp_prs(n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_merged();
        test_set_wins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
